// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - Shared defaults and configuration helpers for the pipelined hybrid adder
package adder_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_BLK        = 4;
  localparam int DEFAULT_STAGE_BITS = 8;

  function automatic int num_stages(input int width, input int stage_bits);
    return width / stage_bits;
  endfunction

  // Legal shapes: the word splits into whole stages, each stage into whole blocks.
  function automatic bit cfg_ok(input int width, input int blk, input int stage_bits);
    return (blk > 0) && (stage_bits > 0) && (width >= stage_bits) &&
           ((width % stage_bits) == 0) && ((stage_bits % blk) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - Combinational BLK-bit carry-look-ahead adder block
module cla_block
  import adder_pkg::*;
#(
  parameter int BLK = DEFAULT_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;
  logic           term;
  logic           prop;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products of generate/propagate terms, not a ripple.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[BLK-1:0];
  assign cout = c[BLK];

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// rtl/pipelined_hybrid_adder.sv - Pipelined add/subtract built from chained CLA blocks
// One STAGE_BITS slice is resolved per stage; operands skew forward, results deskew out.
module pipelined_hybrid_adder
  import adder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int BLK        = DEFAULT_BLK,
  parameter int STAGE_BITS = DEFAULT_STAGE_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out,
  output logic             ovf
);

  localparam int NUM_STAGES = num_stages(WIDTH, STAGE_BITS);
  localparam int NUM_BLKS   = STAGE_BITS / BLK;

  if (!cfg_ok(WIDTH, BLK, STAGE_BITS)) begin : g_cfg_check
    $error("pipelined_hybrid_adder: WIDTH must be a multiple of STAGE_BITS and STAGE_BITS a multiple of BLK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cy_in : cy_in;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - (k + 1) * STAGE_BITS;
    localparam int DONE = (k + 1) * STAGE_BITS;

    logic [STAGE_BITS-1:0] a_s;
    logic [STAGE_BITS-1:0] b_s;
    logic [STAGE_BITS-1:0] s_s;
    logic [NUM_BLKS:0]     c;
    logic                  valid_d;
    logic                  valid_q;
    logic                  carry_q;
    logic [DONE-1:0]       res_d;
    logic [DONE-1:0]       res_q;

    if (k == 0) begin : g_src
      assign a_s     = a[STAGE_BITS-1:0];
      assign b_s     = b_eff[STAGE_BITS-1:0];
      assign c[0]    = c0;
      assign valid_d = in_valid;
      assign res_d   = s_s;
    end else begin : g_src
      assign a_s     = g_stage[k-1].g_rem.a_rem_q[STAGE_BITS-1:0];
      assign b_s     = g_stage[k-1].g_rem.b_rem_q[STAGE_BITS-1:0];
      assign c[0]    = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign res_d   = {s_s, g_stage[k-1].res_q};
    end

    for (genvar j = 0; j < NUM_BLKS; j++) begin : g_cla
      cla_block #(.BLK(BLK)) u_cla (
        .a    (a_s[j*BLK +: BLK]),
        .b    (b_s[j*BLK +: BLK]),
        .cin  (c[j]),
        .sum  (s_s[j*BLK +: BLK]),
        .cout (c[j+1])
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= c[NUM_BLKS];
        res_q   <= res_d;
      end
    end

    // Operand bits above this slice still need to reach later stages.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_rem_d;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_d;
      logic [REM-1:0] b_rem_q;

      if (k == 0) begin : g_rsrc
        assign a_rem_d = a[WIDTH-1:STAGE_BITS];
        assign b_rem_d = b_eff[WIDTH-1:STAGE_BITS];
      end else begin : g_rsrc
        assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[REM+STAGE_BITS-1:STAGE_BITS];
        assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[REM+STAGE_BITS-1:STAGE_BITS];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (adv) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign ovf_d = (a_s[STAGE_BITS-1] ^ b_s[STAGE_BITS-1] ^ s_s[STAGE_BITS-1]) ^ c[NUM_BLKS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].valid_q;
  assign sum       = g_stage[NUM_STAGES-1].res_q;
  assign cy_out    = g_stage[NUM_STAGES-1].carry_q;
  assign ovf       = g_stage[NUM_STAGES-1].g_last.ovf_q;

endmodule
